key_expand_seq: RTL and testbench
=================================

Name: key_expand_seq

Overview:
- Sequential AES key-schedule engine; parametrised successor of the combinational round-constant XOR stage.
- Supports AES-128/192/256 via parameter NK.
- Emits expanded key words w[0..4*(NK+7)-1] one per cycle over a valid/ready stream.
- Generates Rcon internally with a GF(2^8) doubling register instead of a lookup table. SubWord is performed by an external combinational S-box (4 byte S-boxes) through a port pair.

Parameters:
- NK, 4, key length in 32-bit words; legal values 4, 6, 8. Any other value raises an elaboration-time $error.
- NW (localparam), 4*(NK+7), total words emitted: 44, 52 or 60.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start_i  in  1  begin expansion; sampled only in IDLE.
- key_i  in  256  cipher key; word 0 at [255:224]. For NK<8 the low (8-NK)*32 bits are ignored.
- busy_o  out  1  high from the cycle after an accepted start until DONE exits.
- word_valid_o  out  1  word_o is valid.
- word_ready_i  in  1  consumer accepts word_o.
- word_o  out  32  expanded word w[idx].
- word_idx_o  out  6  index of word_o.
- done_o  out  1  one-cycle pulse after the last word is accepted.
- sbox_word_o  out  32  word to substitute; combinational from state.
- sbox_word_i  in  32  SubWord(sbox_word_o); combinational return, same cycle.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy_o=0, word_valid_o=0, word_o=0, word_idx_o=0, done_o=0; rcon=8'h01; window cleared.
- Reset asserted mid-expansion aborts immediately; no further words are emitted.
- States: IDLE, LOAD, EXPAND, DONE.
- IDLE: on start_i=1, capture NK key words into window register win[0..NK-1], set idx=0, rcon=01, go to LOAD. start_i in any other state is ignored.
- LOAD: word_o=key word idx, word_valid_o=1. On valid&ready: idx++. At idx=NK-1 accepted, go to EXPAND.
- EXPAND: temp selection, with prev = w[i-1]:
  - i mod NK==0: sbox_word_o = RotWord(prev) = {prev[23:0],prev[31:24]}; temp = sbox_word_i ^ {rcon,24'h0}.
  - NK==8 and i mod 8==4: sbox_word_o = prev; temp = sbox_word_i.
  - Otherwise: sbox_word_o = prev; temp = prev (S-box result unused).
  - w[i] = w[i-NK] ^ temp. word_o is registered: the computed word appears the cycle after the previous word is accepted.
  - Throughput: 1 word/cycle while ready=1.
- Rcon update: when a word with i mod NK==0 is accepted, rcon <= xtime(rcon) = {rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1b : 8'h00). Sequence: 01,02,04,08,10,20,40,80,1b,36.
- Window: shift register of the last NK words; on acceptance it shifts in the emitted word.
- Backpressure: while valid=1 and ready=0, word_o, word_idx_o and all state hold stable. Valid never drops without acceptance.
- Last word: when word NW-1 is accepted, go to DONE. DONE drives done_o=1 for one cycle, busy_o=0, returns to IDLE, and resets rcon to 01.
- A start_i high in the DONE cycle is ignored; it is accepted the next cycle in IDLE.

Optional Feature:
- Macro KEY_EXPAND_RK_PACK_EN.
- Defined: adds ports rk_valid_o (1), rk_o (128) and rk_idx_o (4).
  - When word 4k+3 is accepted, the next cycle rk_o = {w[4k],w[4k+1],w[4k+2],w[4k+3]}, rk_idx_o=k, and rk_valid_o pulses for 1 cycle.
  - All three reset to 0.
- Undefined: the ports do not exist; no packing register is built.

Test Plan:
- NK=4, key 2b7e151628aed2a6abf7158809cf4f3c, ready=1 -> 44 words; w[4]=a0fafe17, w[43]=b6630ca6; done_o pulses once; Rcon of w[40] is 36.
- NK=6, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> 52 words; w[6]=fe0c91f7, w[51]=01002202.
- NK=8, key 603deb10...0914dff4 -> 60 words; w[8]=9ba35411, w[12]=a8b09c1a (SubWord-only path), w[59]=706c631e.
- NK=4, random word_ready_i toggling -> word_o and word_idx_o stable while stalled; word sequence identical to the no-stall run.
- Assert rst_n=0 at word 20, then restart with the same key -> all outputs go to 0 immediately; the restart produces w[0] first and the full correct sequence.
- start_i pulsed during EXPAND -> ignored, sequence unaffected. With KEY_EXPAND_RK_PACK_EN defined (NK=4): rk_idx_o=10 gives rk_o=d014f9a8c9ee2589e13f0cc8b6630ca6.

Source files
------------

// File: rtl/key_expand_seq_if.sv
// Expanded-key word stream: one 32-bit word plus its index per valid/ready beat.
interface key_expand_seq_if;
  logic        word_valid_o;
  logic        word_ready_i;
  logic [31:0] word_o;
  logic [5:0]  word_idx_o;

  modport master (output word_valid_o, word_o, word_idx_o, input word_ready_i);
  modport slave  (input word_valid_o, word_o, word_idx_o, output word_ready_i);
endinterface

// File: rtl/key_expand_seq.sv
// Sequential AES key schedule (NK=4/6/8), one word per beat, external S-box.
// Optional round-key packing output enabled by macro KEY_EXPAND_RK_PACK_EN.
module key_expand_seq #(
  parameter int NK = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [255:0]          key_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [31:0]           sbox_word_o,
  input  logic [31:0]           sbox_word_i,
  key_expand_seq_if.master      wr
`ifdef KEY_EXPAND_RK_PACK_EN
  ,
  output logic                  rk_valid_o,
  output logic [127:0]          rk_o,
  output logic [3:0]            rk_idx_o
`endif
);
  localparam int NW = 4 * (NK + 7);
  localparam int PW = $clog2(NK);

  typedef enum logic [1:0] {IDLE, LOAD, EXPAND, DONE} state_t;

  generate
    if (NK != 4 && NK != 6 && NK != 8) begin : g_bad_nk
      $error("key_expand_seq: NK must be 4, 6 or 8");
    end
    if (NK < 8) begin : g_unused_key
      wire unused_key = ^key_i[(8-NK)*32-1:0];
    end
  endgenerate

  state_t        state;
  logic [31:0]   win [NK];
  logic [PW-1:0] phase;
  logic [PW-1:0] phase_nxt;
  logic [7:0]    rcon;
  logic [31:0]   temp, base, next_word;
  logic          accept;

  assign accept    = wr.word_valid_o & wr.word_ready_i;
  assign phase_nxt = (phase == PW'(NK-1)) ? '0 : phase + 1'b1;

  // prev is always the word currently on the bus; phase_nxt is the next word's i mod NK
  always_comb begin
    sbox_word_o = wr.word_o;
    temp        = wr.word_o;
    if (phase_nxt == '0) begin
      sbox_word_o = {wr.word_o[23:0], wr.word_o[31:24]};
      temp        = sbox_word_i ^ {rcon, 24'h0};
    end else if (NK == 8 && int'(phase_nxt) == 4) begin
      temp = sbox_word_i;
    end
  end

  // In LOAD the window still holds w[0..NK-1]; in EXPAND it holds w[i-NK..i-1] for bus word i
  assign base      = (state == LOAD) ? win[0] : win[1];
  assign next_word = base ^ temp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      busy_o          <= 1'b0;
      done_o          <= 1'b0;
      wr.word_valid_o <= 1'b0;
      wr.word_o       <= '0;
      wr.word_idx_o   <= '0;
      phase           <= '0;
      rcon            <= 8'h01;
      for (int j = 0; j < NK; j++) win[j] <= '0;
    end else begin
      case (state)
        IDLE: if (start_i) begin
          for (int j = 0; j < NK; j++) win[j] <= key_i[255-32*j -: 32];
          wr.word_o       <= key_i[255 -: 32];
          wr.word_idx_o   <= '0;
          wr.word_valid_o <= 1'b1;
          phase           <= '0;
          rcon            <= 8'h01;
          busy_o          <= 1'b1;
          state           <= LOAD;
        end
        LOAD: if (accept) begin
          if (wr.word_idx_o == 6'(NK-1)) begin
            wr.word_o <= next_word;
            state     <= EXPAND;
          end else begin
            wr.word_o <= win[phase_nxt];
          end
          wr.word_idx_o <= wr.word_idx_o + 6'd1;
          phase         <= phase_nxt;
        end
        EXPAND: if (accept) begin
          if (wr.word_idx_o == 6'(NW-1)) begin
            wr.word_valid_o <= 1'b0;
            busy_o          <= 1'b0;
            done_o          <= 1'b1;
            state           <= DONE;
          end else begin
            wr.word_o     <= next_word;
            wr.word_idx_o <= wr.word_idx_o + 6'd1;
            phase         <= phase_nxt;
            for (int j = 0; j < NK-1; j++) win[j] <= win[j+1];
            win[NK-1] <= wr.word_o;
            if (phase == '0)
              rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
          end
        end
        DONE: begin
          done_o <= 1'b0;
          rcon   <= 8'h01;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef KEY_EXPAND_RK_PACK_EN
  // Last three accepted words; the fourth comes straight off the bus
  logic [95:0] rk_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rk_acc     <= '0;
      rk_valid_o <= 1'b0;
      rk_o       <= '0;
      rk_idx_o   <= '0;
    end else begin
      rk_valid_o <= 1'b0;
      if (accept) begin
        rk_acc <= {rk_acc[63:0], wr.word_o};
        if (wr.word_idx_o[1:0] == 2'd3) begin
          rk_o       <= {rk_acc, wr.word_o};
          rk_idx_o   <= wr.word_idx_o[5:2];
          rk_valid_o <= 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_key_expand_seq.sv
// Directed bench: three engines (NK=4/6/8) fed by a behavioural S-box, checked
// against FIPS-197 vectors and a software key-expansion model.
module tb_key_expand_seq;
  localparam logic [2047:0] SB = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = SB[2047 - 8*int'(w[8*b +: 8]) -: 8];
    return r;
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [2:0]   start, ready, valid, busy, done;
  logic [255:0] key [3];
  logic [31:0]  sbo [3], sbi [3], wd [3];
  logic [5:0]   wi [3];
`ifdef KEY_EXPAND_RK_PACK_EN
  logic         rkv [3];
  logic [127:0] rko [3];
  logic [3:0]   rki [3];
`endif

  key_expand_seq_if wif [3] ();

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign wif[g].word_ready_i = ready[g];
    assign valid[g] = wif[g].word_valid_o;
    assign wd[g]    = wif[g].word_o;
    assign wi[g]    = wif[g].word_idx_o;
    assign sbi[g]   = sub_word(sbo[g]);
    key_expand_seq #(.NK(g == 0 ? 4 : g == 1 ? 6 : 8)) u_dut (
      .clk(clk), .rst_n(rst_n), .start_i(start[g]), .key_i(key[g]),
      .busy_o(busy[g]), .done_o(done[g]), .sbox_word_o(sbo[g]), .sbox_word_i(sbi[g]),
      .wr(wif[g])
`ifdef KEY_EXPAND_RK_PACK_EN
      , .rk_valid_o(rkv[g]), .rk_o(rko[g]), .rk_idx_o(rki[g])
`endif
    );
  end

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  logic [31:0] exp_w [60];
  logic [31:0] got_w [60];

  task automatic build_exp(input int nk, input logic [255:0] k);
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4*(nk+7); i++) begin
      if (i < nk) exp_w[i] = k[255-32*i -: 32];
      else begin
        t = exp_w[i-1];
        if (i % nk == 0) begin
          t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
        end else if (nk == 8 && i % nk == 4) t = sub_word(t);
        exp_w[i] = exp_w[i-nk] ^ t;
      end
    end
  endtask

  // pulse_at/abort_at < 0 disables that event; both are counted in accepted words
  task automatic run(input int sel, input int nk, input bit rnd, input int pulse_at, input int abort_at);
    int n, nw, dones, post, rk_n;
    logic stalled;
    logic [31:0] hw;
    logic [5:0]  hi;
    nw = 4*(nk+7);
    build_exp(nk, key[sel]);
    for (int i = 0; i < 60; i++) got_w[i] = '0;
    n = 0; dones = 0; post = 0; rk_n = 0; stalled = 1'b0; hw = '0; hi = '0;
    @(negedge clk); start[sel] = 1'b1;
    @(negedge clk); start[sel] = 1'b0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      if (done[sel]) dones++;
`ifdef KEY_EXPAND_RK_PACK_EN
      if (sel == 0 && rkv[0]) begin
        chk("rk_idx", 128'(rki[0]), 128'(rk_n));
        chk("rk_word", rko[0], {exp_w[4*rk_n], exp_w[4*rk_n+1], exp_w[4*rk_n+2], exp_w[4*rk_n+3]});
        if (rki[0] == 4'd10) chk("rk10", rko[0], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        rk_n++;
      end
`endif
      if (stalled) begin
        chk("stall_valid", 128'(valid[sel]), 128'(1));
        chk("stall_word", 128'(wd[sel]), 128'(hw));
        chk("stall_idx", 128'(wi[sel]), 128'(hi));
      end
      if (n == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("abort_valid", 128'(valid[sel]), 128'(0));
        chk("abort_word", 128'(wd[sel]), 128'(0));
        chk("abort_idx", 128'(wi[sel]), 128'(0));
        chk("abort_busy", 128'(busy[sel]), 128'(0));
        @(negedge clk); rst_n = 1'b1;
        ready[sel] = 1'b0;
        return;
      end
      ready[sel] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start[sel] = (n == pulse_at);
      if (valid[sel] && ready[sel] && n < nw) begin
        chk("word_idx", 128'(wi[sel]), 128'(n));
        chk("word", 128'(wd[sel]), 128'(exp_w[n]));
        got_w[n] = wd[sel];
        n++;
      end
      stalled = valid[sel] && !ready[sel];
      hw = wd[sel]; hi = wi[sel];
      if (n == nw) post++;
      if (post == 4) break;
      @(negedge clk);
    end
    start[sel] = 1'b0;
    chk("word_count", 128'(n), 128'(nw));
    chk("done_pulses", 128'(dones), 128'(1));
    chk("idle_valid", 128'(valid[sel]), 128'(0));
`ifdef KEY_EXPAND_RK_PACK_EN
    if (sel == 0) chk("rk_count", 128'(rk_n), 128'(11));
`endif
  endtask

  initial begin
    rst_n = 1'b0; start = '0; ready = '0;
    key[0] = 256'h2b7e151628aed2a6abf7158809cf4f3c << 128;
    key[1] = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    key[2] = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    repeat (3) @(negedge clk);
    chk("rst_valid", 128'(valid[0]), 128'(0));
    chk("rst_word", 128'(wd[0]), 128'(0));
    chk("rst_idx", 128'(wi[0]), 128'(0));
    chk("rst_busy", 128'(busy[0]), 128'(0));
    chk("rst_done", 128'(done[0]), 128'(0));
    rst_n = 1'b1;
    @(negedge clk);

    run(0, 4, 1'b0, -1, -1);
    chk("nk4_w4", 128'(got_w[4]), 128'h a0fafe17);
    chk("nk4_w43", 128'(got_w[43]), 128'h b6630ca6);
    run(1, 6, 1'b0, -1, -1);
    chk("nk6_w6", 128'(got_w[6]), 128'h fe0c91f7);
    chk("nk6_w51", 128'(got_w[51]), 128'h 01002202);
    run(2, 8, 1'b0, -1, -1);
    chk("nk8_w8", 128'(got_w[8]), 128'h 9ba35411);
    chk("nk8_w12", 128'(got_w[12]), 128'h a8b09c1a);
    chk("nk8_w59", 128'(got_w[59]), 128'h 706c631e);
    run(0, 4, 1'b1, -1, -1);
    chk("stall_w43", 128'(got_w[43]), 128'h b6630ca6);
    run(0, 4, 1'b0, -1, 20);
    run(0, 4, 1'b0, -1, -1);
    chk("restart_w0", 128'(got_w[0]), 128'h 2b7e1516);
    run(0, 4, 1'b0, 10, -1);
    chk("pulse_w43", 128'(got_w[43]), 128'h b6630ca6);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
